// File: rtl/ssd_scan_mux.sv
// N-digit seven-segment controller: synchronised load strobe writes hex nibbles into a ring of digit
// slots, a prescaled scan multiplexes the anodes. Optional decimal-point cursor under SSD_DP_EN.
module ssd_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int PTR_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [3:0]            user_inp,
  output logic [NUM_DIGITS-1:0] active_digit,
  output logic [6:0]            seven_out,
`ifdef SSD_DP_EN
  output logic                  dp,
`endif
  output logic [PTR_W-1:0]      wr_ptr
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic                  s1, s2, s2_d;
  logic                  load_evt;
  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid;
  logic [PRE_W-1:0]      prescaler;
  logic [PTR_W-1:0]      scan_idx;
  logic                  pre_tc;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
`ifdef SSD_DP_EN
  logic                  dp_nxt;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign load_evt = s2 & ~s2_d;
  assign pre_tc   = (prescaler == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= load;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  // Clear has priority over a coincident load event; the nibble is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 4'h0;
      valid  <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 4'h0;
      valid  <= '0;
      wr_ptr <= '0;
    end else if (load_evt) begin
      digit[wr_ptr] <= user_inp;
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= (wr_ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else if (pre_tc) begin
      prescaler <= '0;
      scan_idx  <= (scan_idx == PTR_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    if (valid[scan_idx]) begin
      an_nxt  = ~(NUM_DIGITS'(1) << scan_idx);
      seg_nxt = decode(digit[scan_idx]);
    end
`ifdef SSD_DP_EN
    // Cursor: light the slot the next load will fill, even if it is still empty.
    dp_nxt = 1'b1;
    if (scan_idx == wr_ptr) begin
      an_nxt = ~(NUM_DIGITS'(1) << scan_idx);
      dp_nxt = 1'b0;
    end
`endif
  end

  // Anodes and segments share one edge so no digit ever shows a neighbour's pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_digit <= '1;
      seven_out    <= 7'h7F;
`ifdef SSD_DP_EN
      dp           <= 1'b1;
`endif
    end else begin
      active_digit <= an_nxt;
      seven_out    <= seg_nxt;
`ifdef SSD_DP_EN
      dp           <= dp_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux (4 digits, refresh 4): a cycle model pushes expected outputs per edge,
// the negedge process pops and compares; directed checks cover the load/clear/reset scenarios.
module tb_ssd_scan_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] user_inp = 4'h0;
  logic [3:0] active_digit;
  logic [6:0] seven_out;
  logic [1:0] wr_ptr;
`ifdef SSD_DP_EN
  logic       dp;
`endif

  int total = 0;
  int bad   = 0;
  int seen5 = 0;

  ssd_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .clear(clear),
    .user_inp(user_inp),
    .active_digit(active_digit),
    .seven_out(seven_out),
`ifdef SSD_DP_EN
    .dp(dp),
`endif
    .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] wp;
`ifdef SSD_DP_EN
    logic       dp;
`endif
  } exp_t;

  exp_t sbq[$];
  exp_t e_new, e_cur;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       m_s1, m_s2, m_s2d, m_evt;
  logic [3:0] m_dig [4];
  logic [3:0] m_val;
  logic [1:0] m_wp, m_scan;
  int         m_pre;

  // Reference model: outputs follow the pre-edge scan position and storage.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_s2d = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      m_val = 4'h0; m_wp = 2'd0; m_scan = 2'd0; m_pre = 0;
      sbq.delete();
    end else begin
      e_new.an  = 4'hF;
      e_new.seg = 7'h7F;
      if (m_val[m_scan]) begin
        e_new.an  = ~(4'b0001 << m_scan);
        e_new.seg = dec[m_dig[m_scan]];
      end
`ifdef SSD_DP_EN
      e_new.dp = 1'b1;
      if (m_scan == m_wp) begin
        e_new.an = ~(4'b0001 << m_scan);
        e_new.dp = 1'b0;
      end
`endif
      m_evt = m_s2 & ~m_s2d;
      m_s2d = m_s2; m_s2 = m_s1; m_s1 = load;
      if (clear) begin
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_val = 4'h0; m_wp = 2'd0;
      end else if (m_evt) begin
        m_dig[m_wp] = user_inp;
        m_val[m_wp] = 1'b1;
        m_wp = m_wp + 2'd1;
      end
      e_new.wp = m_wp;
      if (m_pre == 3) begin
        m_pre = 0;
        m_scan = m_scan + 2'd1;
      end else begin
        m_pre++;
      end
      sbq.push_back(e_new);
    end
  end

  always @(negedge clk) begin
    if (!reset && sbq.size() > 0) begin
      e_cur = sbq.pop_front();
      chk("sb_anode", 32'(active_digit), 32'(e_cur.an));
      chk("sb_seg", 32'(seven_out), 32'(e_cur.seg));
      chk("sb_wrptr", 32'(wr_ptr), 32'(e_cur.wp));
`ifdef SSD_DP_EN
      chk("sb_dp", 32'(dp), 32'(e_cur.dp));
`endif
      if (seven_out == 7'h12) seen5++;
    end
  end

  task automatic load_nib(input logic [3:0] v, input int hold);
    @(negedge clk);
    user_inp = v;
    load = 1'b1;
    repeat (hold) @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic observe(input string tag, input logic [3:0] an, input logic [6:0] seg);
    int n = 0;
    bit found = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      #1;
      if (active_digit == an) begin
        chk(tag, 32'(seven_out), 32'(seg));
        found = 1;
      end
      n++;
    end
    if (!found) chk({tag, "_timeout"}, 32'(active_digit), 32'(an));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(active_digit), 32'hF);
    chk("rst_seg", 32'(seven_out), 32'h7F);
    chk("rst_wrptr", 32'(wr_ptr), 32'h0);
    reset = 1'b0;
    repeat (64) @(negedge clk);
    chk("idle_anode", 32'(active_digit), 32'hF);

    load_nib(4'h3, 10);
    chk("single_wrptr", 32'(wr_ptr), 32'h1);
    observe("single_slot0", 4'b1110, 7'h30);

    clear_pulse();
    load_nib(4'h1, 3);
    load_nib(4'h2, 3);
    load_nib(4'hA, 3);
    load_nib(4'hF, 3);
    load_nib(4'h8, 3);
    chk("wrap_wrptr", 32'(wr_ptr), 32'h1);
    observe("wrap_slot0", 4'b1110, 7'h00);
    observe("wrap_slot1", 4'b1101, 7'h24);
    observe("wrap_slot2", 4'b1011, 7'h08);
    observe("wrap_slot3", 4'b0111, 7'h0E);

    // Load rises before edge N so its event lands on edge N+2 together with clear.
    @(negedge clk);
    user_inp = 4'h5;
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    load = 1'b0;
    chk("clr_wrptr", 32'(wr_ptr), 32'h0);
    repeat (16) @(negedge clk);
    chk("clr_no5", 32'(seen5), 32'h0);
`ifndef SSD_DP_EN
    chk("clr_dark", 32'(active_digit), 32'hF);
`endif

    load_nib(4'h4, 3);
    load_nib(4'h6, 3);
    load_nib(4'h9, 3);
    observe("pre_rst_slot1", 4'b1101, 7'h02);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_anode", 32'(active_digit), 32'hF);
    chk("arst_seg", 32'(seven_out), 32'h7F);
    chk("arst_wrptr", 32'(wr_ptr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    load_nib(4'h7, 3);
    chk("post_rst_wrptr", 32'(wr_ptr), 32'h1);
    observe("post_rst_slot0", 4'b1110, 7'h78);

`ifdef SSD_DP_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load_nib(4'h1, 3);
    load_nib(4'h2, 3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      chk("dp_cursor", 32'(dp), 32'(active_digit != 4'b1011));
    end
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
